// File: rtl/demo_dose_sequencer.sv
// rtl/demo_dose_sequencer.sv - prime/dose/flush valve and pump sequencer feeding the demo mixer
// Optional flush phase: define DEMO_SEQ_FLUSH_EN to compile in the FLUSH state.
module demo_dose_sequencer #(
    parameter int CNT_W        = 16,
    parameter int PRIME_CYCLES = 8,
    parameter int FLUSH_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] dose1_len,
    input  logic [CNT_W-1:0] dose2_len,
    input  logic [CNT_W-1:0] dose3_len,
    output logic             ready,
    output logic             busy,
    output logic             pump_en,
    output logic             valve_soln1,
    output logic             valve_soln2,
    output logic             valve_soln3,
    output logic             done,
    output logic             aborted
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRIME = 3'd1,
        S_DOSE1 = 3'd2,
        S_DOSE2 = 3'd3,
        S_DOSE3 = 3'd4,
        S_FLUSH = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] PRIME_LOAD = CNT_W'(PRIME_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    state_t           adv_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] adv_cnt;
    logic [CNT_W-1:0] len1;
    logic [CNT_W-1:0] len2;
    logic [CNT_W-1:0] len3;
    logic             accept;
    logic             abort_take;

    logic ready_d;
    logic busy_d;
    logic pump_d;
    logic valve1_d;
    logic valve2_d;
    logic valve3_d;
    logic done_d;
    logic aborted_d;

    // State, counter, latched lengths and the registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            len1        <= '0;
            len2        <= '0;
            len3        <= '0;
            ready       <= 1'b1;
            busy        <= 1'b0;
            pump_en     <= 1'b0;
            valve_soln1 <= 1'b0;
            valve_soln2 <= 1'b0;
            valve_soln3 <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                len1 <= dose1_len;
                len2 <= dose2_len;
                len3 <= dose3_len;
            end
            ready       <= ready_d;
            busy        <= busy_d;
            pump_en     <= pump_d;
            valve_soln1 <= valve1_d;
            valve_soln2 <= valve2_d;
            valve_soln3 <= valve3_d;
            done        <= done_d;
            aborted     <= aborted_d;
        end
    end

    always_comb begin
        accept     = (state == S_IDLE) && start && !abort;
        abort_take = abort && (state != S_IDLE) && (state != S_DONE);

        // Tail phase after the last dose; in the no-flush build the count
        // loaded on entry to DONE is never consumed.
`ifdef DEMO_SEQ_FLUSH_EN
        adv_state = S_FLUSH;
`else
        adv_state = S_DONE;
`endif
        adv_cnt = FLUSH_LOAD;
        // Later assignments take priority, so the earliest nonzero dose wins
        if ((state == S_PRIME || state == S_DOSE1 || state == S_DOSE2) && len3 != '0) begin
            adv_state = S_DOSE3;
            adv_cnt   = len3 - 1'b1;
        end
        if ((state == S_PRIME || state == S_DOSE1) && len2 != '0) begin
            adv_state = S_DOSE2;
            adv_cnt   = len2 - 1'b1;
        end
        if (state == S_PRIME && len1 != '0) begin
            adv_state = S_DOSE1;
            adv_cnt   = len1 - 1'b1;
        end

        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_PRIME;
                    cnt_nxt   = PRIME_LOAD;
                end
            end
            S_PRIME, S_DOSE1, S_DOSE2, S_DOSE3: begin
                if (cnt == '0) begin
                    state_nxt = adv_state;
                    cnt_nxt   = adv_cnt;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
`ifdef DEMO_SEQ_FLUSH_EN
            S_FLUSH: begin
                if (cnt == '0) begin
                    state_nxt = S_DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
`endif
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        if (abort_take) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
        end
    end

    // Outputs are decoded from the next state so they line up with the state register
    always_comb begin
        ready_d   = (state_nxt == S_IDLE);
        busy_d    = (state_nxt == S_PRIME) || (state_nxt == S_DOSE1) || (state_nxt == S_DOSE2) ||
                    (state_nxt == S_DOSE3) || (state_nxt == S_FLUSH);
        pump_d    = busy_d;
        valve1_d  = (state_nxt == S_DOSE1);
        valve2_d  = (state_nxt == S_DOSE2);
        valve3_d  = (state_nxt == S_DOSE3) || (state_nxt == S_FLUSH);
        done_d    = (state_nxt == S_DONE);
        aborted_d = abort_take;
    end

endmodule

// File: tb/tb_demo_dose_sequencer.sv
// tb/tb_demo_dose_sequencer.sv - randomized self-checking bench for demo_dose_sequencer
module tb_demo_dose_sequencer;

    localparam int P = 8;
`ifdef DEMO_SEQ_FLUSH_EN
    localparam int F = 32;
`else
    localparam int F = 0;
`endif

    localparam logic [7:0] V_IDLE  = 8'b1000_0000;
    localparam logic [7:0] V_PRIME = 8'b0110_0000;
    localparam logic [7:0] V_D1    = 8'b0111_0000;
    localparam logic [7:0] V_D2    = 8'b0110_1000;
    localparam logic [7:0] V_D3    = 8'b0110_0100;
    localparam logic [7:0] V_DONE  = 8'b0000_0010;
    localparam logic [7:0] V_ABORT = 8'b1000_0001;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] dose1_len;
    logic [15:0] dose2_len;
    logic [15:0] dose3_len;
    logic        ready;
    logic        busy;
    logic        pump_en;
    logic        valve_soln1;
    logic        valve_soln2;
    logic        valve_soln3;
    logic        done;
    logic        aborted;
    logic [7:0]  obs;

    int n_cmp = 0;
    int n_bad = 0;

    demo_dose_sequencer #(
        .CNT_W       (16),
        .PRIME_CYCLES(8),
        .FLUSH_CYCLES(32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .dose1_len  (dose1_len),
        .dose2_len  (dose2_len),
        .dose3_len  (dose3_len),
        .ready      (ready),
        .busy       (busy),
        .pump_en    (pump_en),
        .valve_soln1(valve_soln1),
        .valve_soln2(valve_soln2),
        .valve_soln3(valve_soln3),
        .done       (done),
        .aborted    (aborted)
    );

    assign obs = {ready, busy, pump_en, valve_soln1, valve_soln2, valve_soln3, done, aborted};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {ready,busy,pump,v1,v2,v3,done,aborted} for cycle k of a run accepted at edge 0
    function automatic logic [7:0] exp_vec(input int k, input int l1, input int l2, input int l3);
        int s;
        int t;
        s = l1 + l2 + l3;
        t = k - P;
        if (k <= 0)              return V_IDLE;
        if (k <= P)              return V_PRIME;
        if (t <= l1)             return V_D1;
        if (t <= l1 + l2)        return V_D2;
        if (t <= s)              return V_D3;
        if (t <= s + F)          return V_D3;
        if (k == 1 + P + s + F)  return V_DONE;
        return V_IDLE;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int l1, input int l2, input int l3);
        dose1_len = 16'(l1);
        dose2_len = 16'(l2);
        dose3_len = 16'(l3);
        start = 1'b1;
        abort = 1'b0;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        dose1_len = '0;
        dose2_len = '0;
        dose3_len = '0;
        repeat (3) begin
            tick();
            n_cmp++;
            if (obs !== V_IDLE) begin
                n_bad++;
                $display("FAIL reset_hold obs=%b exp=%b", obs, V_IDLE);
            end
        end
        rst_n = 1'b1;
        repeat (4) begin
            tick();
            n_cmp++;
            if (obs !== V_IDLE) begin
                n_bad++;
                $display("FAIL reset_idle obs=%b exp=%b", obs, V_IDLE);
            end
        end
    endtask

    task automatic test_nominal();
        int done_at;
        logic [7:0] e;
        done_at = -1;
        start_run(4, 6, 2);
        for (int k = 1; k <= P + 12 + F + 2; k++) begin
            e = exp_vec(k, 4, 6, 2);
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL nominal cyc=%0d obs=%b exp=%b", k, obs, e);
            end
            if (done === 1'b1 && done_at < 0) done_at = k;
            tick();
        end
        n_cmp++;
`ifdef DEMO_SEQ_FLUSH_EN
        if (done_at !== 53) begin
            n_bad++;
            $display("FAIL nominal_done_cycle got=%0d exp=53", done_at);
        end
`else
        if (done_at !== 21) begin
            n_bad++;
            $display("FAIL nominal_done_cycle got=%0d exp=21", done_at);
        end
`endif
    endtask

    task automatic test_zero_skip();
        logic [7:0] e;
        int v2_seen;
        v2_seen = 0;
        start_run(3, 0, 5);
        for (int k = 1; k <= P + 8 + F + 2; k++) begin
            e = exp_vec(k, 3, 0, 5);
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL zero_skip cyc=%0d obs=%b exp=%b", k, obs, e);
            end
            if (valve_soln2 === 1'b1) v2_seen++;
            tick();
        end
        n_cmp++;
        if (v2_seen !== 0) begin
            n_bad++;
            $display("FAIL zero_skip_v2 cycles=%0d exp=0", v2_seen);
        end
    endtask

    task automatic test_random();
        int l1, l2, l3;
        logic [7:0] e;
        for (int r = 0; r < 8; r++) begin
            if (r == 0) begin
                l1 = 0; l2 = 0; l3 = 0;
            end else begin
                l1 = $urandom_range(0, 6);
                l2 = $urandom_range(0, 6);
                l3 = $urandom_range(0, 6);
            end
            start_run(l1, l2, l3);
            for (int k = 1; k <= P + l1 + l2 + l3 + F + 2; k++) begin
                e = exp_vec(k, l1, l2, l3);
                n_cmp++;
                if (obs !== e) begin
                    n_bad++;
                    $display("FAIL random run=%0d len=%0d/%0d/%0d cyc=%0d obs=%b exp=%b",
                             r, l1, l2, l3, k, obs, e);
                end
                tick();
            end
        end
    endtask

    task automatic test_abort();
        logic [7:0] e;
        start_run(4, 6, 2);
        for (int k = 1; k <= 15; k++) begin
            e = exp_vec(k, 4, 6, 2);
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL abort_pre cyc=%0d obs=%b exp=%b", k, obs, e);
            end
            if (k == 15) abort = 1'b1;
            tick();
        end
        abort = 1'b0;
        n_cmp++;
        if (obs !== V_ABORT) begin
            n_bad++;
            $display("FAIL abort_cycle16 obs=%b exp=%b", obs, V_ABORT);
        end
        start_run(2, 3, 1);
        for (int k = 1; k <= P + 6 + F + 2; k++) begin
            e = exp_vec(k, 2, 3, 1);
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL abort_restart cyc=%0d obs=%b exp=%b", k, obs, e);
            end
            tick();
        end
    endtask

    task automatic test_busy_start();
        logic [7:0] e;
        start_run(4, 6, 2);
        for (int k = 1; k <= P + 12 + F + 2; k++) begin
            e = exp_vec(k, 4, 6, 2);
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL busy_start cyc=%0d obs=%b exp=%b", k, obs, e);
            end
            if (k == 10) begin
                start = 1'b1;
                dose2_len = 16'd100;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        repeat (3) begin
            n_cmp++;
            if (obs !== V_IDLE) begin
                n_bad++;
                $display("FAIL start_abort_idle obs=%b exp=%b", obs, V_IDLE);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int a1, a2, a3, b1, b2, b3;
        logic [7:0] e;
        a1 = $urandom_range(0, 5); a2 = $urandom_range(0, 5); a3 = $urandom_range(1, 5);
        b1 = $urandom_range(1, 5); b2 = $urandom_range(0, 5); b3 = $urandom_range(0, 5);
        start_run(a1, a2, a3);
        for (int k = 1; k <= P + a1 + a2 + a3 + F + 1; k++) begin
            e = exp_vec(k, a1, a2, a3);
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL b2b_first cyc=%0d obs=%b exp=%b", k, obs, e);
            end
            tick();
        end
        n_cmp++;
        if (obs !== V_IDLE) begin
            n_bad++;
            $display("FAIL b2b_ready obs=%b exp=%b", obs, V_IDLE);
        end
        start_run(b1, b2, b3);
        for (int k = 1; k <= P + b1 + b2 + b3 + F + 2; k++) begin
            e = exp_vec(k, b1, b2, b3);
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL b2b_second cyc=%0d obs=%b exp=%b", k, obs, e);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] e;
        start_run(4, 6, 2);
        for (int k = 1; k <= 9; k++) tick();
        e = exp_vec(10, 4, 6, 2);
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL async_pre obs=%b exp=%b", obs, e);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== V_IDLE) begin
            n_bad++;
            $display("FAIL async_immediate obs=%b exp=%b", obs, V_IDLE);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (obs !== V_IDLE) begin
            n_bad++;
            $display("FAIL async_after obs=%b exp=%b", obs, V_IDLE);
        end
        start_run(1, 1, 1);
        for (int k = 1; k <= P + 3 + F + 2; k++) begin
            e = exp_vec(k, 1, 1, 1);
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL async_rerun cyc=%0d obs=%b exp=%b", k, obs, e);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_zero_skip();
        test_random();
        test_abort();
        test_busy_start();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/demo_dose_sequencer.md
# demo_dose_sequencer

Timed valve/pump sequencer that sits directly upstream of the `demo` mixing netlist and drives its three fluid inputs `soln1`, `soln2` and `soln3`. On a start request it primes the line, then opens one inlet valve at a time for a programmed number of cycles, optionally flushes, and signals completion. The register-level outputs drive the off-chip pneumatic valve and pump drivers feeding the serpentine/diffmix chain.

## Interface
Parameters:
- `CNT_W`, 16: width of the dose-length inputs and the internal down-counter.
- `PRIME_CYCLES`, 8: pump-only priming duration in cycles. Must be ≥1.
- `FLUSH_CYCLES`, 32: flush duration in cycles. Must be ≥1. Used only when flush is compiled in.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: run request. Sampled only while `ready`=1.
- `abort` in 1: abort request. Sampled in any non-IDLE state.
- `dose1_len` in CNT_W: open cycles for the `soln1` valve. Latched on an accepted start.
- `dose2_len` in CNT_W: open cycles for the `soln2` valve. Latched on an accepted start.
- `dose3_len` in CNT_W: open cycles for the `soln3` valve. Latched on an accepted start.
- `ready` out 1: high in IDLE.
- `busy` out 1: high in PRIME, DOSE1–3 and FLUSH.
- `pump_en` out 1: pressure pump on.
- `valve_soln1` out 1: inlet valve for `soln1`.
- `valve_soln2` out 1: inlet valve for `soln2`.
- `valve_soln3` out 1: inlet valve for `soln3`.
- `done` out 1: one-cycle pulse on normal completion.
- `aborted` out 1: one-cycle pulse on abort.

## Operation
- States: IDLE, PRIME, DOSE1, DOSE2, DOSE3, FLUSH, DONE.
- All outputs are registered.
- **Reset values:** state=IDLE, `ready`=1, all other outputs 0, counter 0, latched lengths 0.
- **IDLE:**
  - On `start`=1 and `abort`=0: latch the three lengths, load the counter with PRIME_CYCLES-1, go to PRIME.
  - When `start` and `abort` are both 1 in IDLE, remain in IDLE with no pulse.
- **PRIME:** `pump_en`=1, all valves closed.
- **DOSE1, DOSE2, DOSE3:** `pump_en`=1 plus exactly the matching valve.
- **Counter and phase advance:**
  - The counter decrements every cycle.
  - When it reaches 0, advance to the next phase whose latched length is nonzero and load that length minus 1.
  - Zero-length doses are skipped in zero cycles.
  - If all three lengths are 0, PRIME goes straight to FLUSH, or to DONE when flush is not compiled in.
- **FLUSH:** `pump_en`=1, `valve_soln3`=1 (`soln3` is the carrier buffer), for FLUSH_CYCLES cycles.
- **DONE:** one cycle. `done`=1, `busy`=0, `pump_en`=0, valves closed. The next state is IDLE.
- **Valve exclusivity:** at most one valve is open in any cycle. A valve is never open while `pump_en`=0.
- **Start while busy:** `start` is ignored outside IDLE. Changes to the length inputs after latching have no effect.
- **Abort:** `abort`=1 in any of PRIME, DOSE1–3 or FLUSH:
  - The next cycle is IDLE with pump and valves 0 and `aborted`=1 for that one cycle.
  - `ready`=1 in that same cycle.
- **Abort in DONE:** ignored. `done` still pulses.
- **Asynchronous reset mid-run:** all outputs go to their reset values immediately, without waiting for a clock edge.

## Timing
- Let P=PRIME_CYCLES, F=FLUSH_CYCLES (F=0 when flush is not compiled in), and L1–L3 the latched lengths.
- With `start` accepted at edge 0:
  - PRIME occupies cycles 1..P.
  - DOSE1 begins at cycle P+1.
  - `done` is high at cycle 1+P+L1+L2+L3+F.
  - `ready` returns the following cycle.
- Start-to-first-output latency is 1 cycle. Abort-to-outputs-off latency is 1 cycle.
- A back-to-back `start` is accepted in the first IDLE cycle after DONE.

## Configuration
- `DEMO_SEQ_FLUSH_EN` defined: the FLUSH state is present, and FLUSH_CYCLES of `soln3` carrier flow follow the last dose.
- Not defined: the FLUSH state is not compiled. The last dose phase goes directly to DONE and FLUSH_CYCLES is unused.

## Test plan
All scenarios use P=8, F=32 and CNT_W=16.
- **Reset:** hold `rst_n`=0 for 3 cycles, then release → `ready`=1 and all other outputs 0 throughout. No activity until `start`.
- **Nominal run, lengths 4/6/2, flush compiled in** → pump on for cycles 1–52.
  - Valves: `valve_soln1` for cycles 9–12, `valve_soln2` for 13–18, `valve_soln3` for 19–20, flush `valve_soln3` for 21–52.
  - `done` at cycle 53. Without the macro, `done` is at cycle 21.
- **Zero-length skip, lengths 3/0/5:** `valve_soln2` never asserts. `valve_soln1` covers cycles 9–11 and `valve_soln3` covers cycles 12–16. No gap cycle between them.
- **Abort during DOSE2 (lengths 4/6/2), abort at cycle 15:**
  - Cycle 16: all valves and pump 0, `aborted`=1, `ready`=1, `done` never pulses.
  - A new `start` at cycle 16 is accepted.
- **Start while busy and input changes:**
  - Pulse `start` at cycle 10 while changing `dose2_len` to 100 → ignored. The run matches the nominal timing exactly.
  - `start` and `abort` together in IDLE → remains IDLE with no pulse.
- **Asynchronous reset mid-DOSE1:** drop `rst_n` between clock edges at cycle 10 → `pump_en` and `valve_soln1` fall immediately. After release the block is in IDLE with `ready`=1.
